// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the memory access arbiter
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_access_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int TIMEOUT_WIDTH = 8;

endpackage

// File: rtl/mem_access_rr_arbiter.sv
// rtl/mem_access_rr_arbiter.sv - combinational two-way round-robin grant
module mem_access_rr_arbiter
    import mem_access_pkg::*;
(
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = fetch_req_i | data_req_i;
        grant_id_o    = REQ_FETCH;
        // On a tie the requester that did not win last time goes first.
        if (fetch_req_i && data_req_i) begin
            grant_id_o = ~last_grant_i;
        end else if (data_req_i) begin
            grant_id_o = REQ_DATA;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares the main-memory port between fetch and data paths
module mem_access_arbiter
    import mem_access_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     MEM_ACCESS_ARBITER_CLOCK_50,
    input  logic                     MEM_ACCESS_ARBITER_RESET_InLow,
    input  logic                     MEM_ACCESS_ARBITER_FETCH_REQ_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_FETCH_ADDR_InBUS,
    output logic                     MEM_ACCESS_ARBITER_FETCH_DONE_Out,
    input  logic                     MEM_ACCESS_ARBITER_DATA_REQ_In,
    input  logic                     MEM_ACCESS_ARBITER_DATA_WE_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_DATA_ADDR_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_DATA_WDATA_InBUS,
    output logic                     MEM_ACCESS_ARBITER_DATA_DONE_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_RDATA_OutBUS,
    output logic                     MEM_ACCESS_ARBITER_ERROR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MEM_ADDR_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MEM_WDATA_OutBUS,
    output logic                     MEM_ACCESS_ARBITER_MEM_RD_Out,
    output logic                     MEM_ACCESS_ARBITER_MEM_WR_Out,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MEM_RDATA_InBUS,
    input  logic                     MEM_ACCESS_ARBITER_MEM_ACK_In
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX     = '1;

    logic clk;
    logic rst_n;
    logic ack;
    assign clk   = MEM_ACCESS_ARBITER_CLOCK_50;
    assign rst_n = MEM_ACCESS_ARBITER_RESET_InLow;
    assign ack   = MEM_ACCESS_ARBITER_MEM_ACK_In;

    mem_access_state_e state_q, state_d;

    logic                     last_grant_q, last_grant_d;
    logic                     grant_q, grant_d;
    logic                     we_q, we_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
    logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic                     fetch_done_q, fetch_done_d;
    logic                     data_done_q, data_done_d;
    logic                     error_q, error_d;

    logic gnt_valid;
    logic gnt_id;
    logic sel_we;
    logic timed_out;

    mem_access_rr_arbiter u_rr_arbiter (
        .fetch_req_i   (MEM_ACCESS_ARBITER_FETCH_REQ_In),
        .data_req_i    (MEM_ACCESS_ARBITER_DATA_REQ_In),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (gnt_valid),
        .grant_id_o    (gnt_id)
    );

    assign timed_out = (cnt_q == TIMEOUT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ACCESS;
            ACCESS:  if (ack || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        sel_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d      = gnt_id;
                    last_grant_d = gnt_id;
                    cnt_d        = '0;
                    if (gnt_id == REQ_FETCH) begin
                        sel_we  = 1'b0;
                        addr_d  = MEM_ACCESS_ARBITER_FETCH_ADDR_InBUS;
                        wdata_d = '0;
                    end else begin
                        sel_we  = MEM_ACCESS_ARBITER_DATA_WE_In;
                        addr_d  = MEM_ACCESS_ARBITER_DATA_ADDR_InBUS;
                        wdata_d = MEM_ACCESS_ARBITER_DATA_WDATA_InBUS;
                    end
                    we_d = sel_we;
                    rd_d = ~sel_we;
                    wr_d = sel_we;
                end
            end
            ACCESS: begin
                // ACK takes priority over a timeout landing on the same cycle.
                if (ack || timed_out) begin
                    if (ack && !we_q) begin
                        rdata_d = MEM_ACCESS_ARBITER_MEM_RDATA_InBUS;
                    end
                    error_d      = ~ack;
                    fetch_done_d = (grant_q == REQ_FETCH);
                    data_done_d  = (grant_q == REQ_DATA);
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    rd_d  = ~we_q;
                    wr_d  = we_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_DATA;
            grant_q      <= REQ_FETCH;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
            error_q      <= error_d;
        end
    end

    assign MEM_ACCESS_ARBITER_FETCH_DONE_Out   = fetch_done_q;
    assign MEM_ACCESS_ARBITER_DATA_DONE_Out    = data_done_q;
    assign MEM_ACCESS_ARBITER_RDATA_OutBUS     = rdata_q;
    assign MEM_ACCESS_ARBITER_ERROR_Out        = error_q;
    assign MEM_ACCESS_ARBITER_MEM_ADDR_OutBUS  = addr_q;
    assign MEM_ACCESS_ARBITER_MEM_WDATA_OutBUS = wdata_q;
    assign MEM_ACCESS_ARBITER_MEM_RD_Out       = rd_q;
    assign MEM_ACCESS_ARBITER_MEM_WR_Out       = wr_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed vector bench for mem_access_arbiter
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_done;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(15)) dut (
        .MEM_ACCESS_ARBITER_CLOCK_50         (clk),
        .MEM_ACCESS_ARBITER_RESET_InLow      (rst_n),
        .MEM_ACCESS_ARBITER_FETCH_REQ_In     (fetch_req),
        .MEM_ACCESS_ARBITER_FETCH_ADDR_InBUS (fetch_addr),
        .MEM_ACCESS_ARBITER_FETCH_DONE_Out   (fetch_done),
        .MEM_ACCESS_ARBITER_DATA_REQ_In      (data_req),
        .MEM_ACCESS_ARBITER_DATA_WE_In       (data_we),
        .MEM_ACCESS_ARBITER_DATA_ADDR_InBUS  (data_addr),
        .MEM_ACCESS_ARBITER_DATA_WDATA_InBUS (data_wdata),
        .MEM_ACCESS_ARBITER_DATA_DONE_Out    (data_done),
        .MEM_ACCESS_ARBITER_RDATA_OutBUS     (rdata),
        .MEM_ACCESS_ARBITER_ERROR_Out        (err),
        .MEM_ACCESS_ARBITER_MEM_ADDR_OutBUS  (mem_addr),
        .MEM_ACCESS_ARBITER_MEM_WDATA_OutBUS (mem_wdata),
        .MEM_ACCESS_ARBITER_MEM_RD_Out       (mem_rd),
        .MEM_ACCESS_ARBITER_MEM_WR_Out       (mem_wr),
        .MEM_ACCESS_ARBITER_MEM_RDATA_InBUS  (mem_rdata),
        .MEM_ACCESS_ARBITER_MEM_ACK_In       (mem_ack)
    );

    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] mrdata;
        logic        rd;
        logic        wr;
        logic        fd;
        logic        dd;
        logic        er;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          rd_cycles;
        int          edges;
        int          overlap;
        int          bad_addr;
        int          n_done;
        logic        got_done;
        logic [31:0] order [4];

        // inputs: freq faddr dreq dwe daddr dwdata ack mrdata | expected: rd wr fd dd err addr wdata rdata
        vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
        vecs[4]  = vecs[3];
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h99, 32'hFFFFFFFF, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
        vecs[6]  = vecs[3];
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h55, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h55, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h55, 1'b1, 32'h0BADF00D,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h55, 32'h0BADF00D};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11111111,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h55, 32'h0BADF00D};
        vecs[12] = vecs[11];

        repeat (2) tick();
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_fdone", fetch_done, 1'b0);
        chk("rst_ddone", data_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            fetch_req  = vecs[i].freq;
            fetch_addr = vecs[i].faddr;
            data_req   = vecs[i].dreq;
            data_we    = vecs[i].dwe;
            data_addr  = vecs[i].daddr;
            data_wdata = vecs[i].dwdata;
            mem_ack    = vecs[i].ack;
            mem_rdata  = vecs[i].mrdata;
            tick();
            chk($sformatf("v%0d_rd", i), mem_rd, vecs[i].rd);
            chk($sformatf("v%0d_wr", i), mem_wr, vecs[i].wr);
            chk($sformatf("v%0d_fdone", i), fetch_done, vecs[i].fd);
            chk($sformatf("v%0d_ddone", i), data_done, vecs[i].dd);
            chk($sformatf("v%0d_err", i), err, vecs[i].er);
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdat);
        end
        mem_ack = 1'b0;

        // Timeout: no ACK at all.
        fetch_req  = 1'b1;
        fetch_addr = 32'h80;
        rd_cycles  = 0;
        edges      = 0;
        got_done   = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            edges++;
            if (mem_rd) rd_cycles++;
            if (fetch_done) begin
                got_done  = 1'b1;
                fetch_req = 1'b0;
            end
        end
        chk("to_done_seen", got_done, 1'b1);
        chk("to_rd_cycles", rd_cycles, 16);
        chk("to_latency", edges, 17);
        chk("to_err", err, 1'b1);
        chk("to_rdata_kept", rdata, 32'h0BADF00D);

        // Late ACK lands in DONE then IDLE and must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("late_ack_rd", mem_rd, 1'b0);
            chk("late_ack_fdone", fetch_done, 1'b0);
            chk("late_ack_err_hold", err, 1'b1);
            chk("late_ack_rdata", rdata, 32'h0BADF00D);
        end
        mem_ack = 1'b0;

        // ACK on the very cycle the counter reaches the limit.
        fetch_req  = 1'b1;
        fetch_addr = 32'h90;
        tick();
        rd_cycles = mem_rd ? 1 : 0;
        repeat (15) begin
            tick();
            if (mem_rd) rd_cycles++;
        end
        chk("ack15_rd_cycles", rd_cycles, 16);
        chk("ack15_no_early_done", fetch_done, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        tick();
        chk("ack15_fdone", fetch_done, 1'b1);
        chk("ack15_err", err, 1'b0);
        chk("ack15_rdata", rdata, 32'h5A5A5A5A);
        fetch_req = 1'b0;
        mem_ack   = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a write.
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h300;
        data_wdata = 32'h77;
        tick();
        chk("mid_wr_up", mem_wr, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", mem_wr, 1'b0);
        chk("mid_rst_rd", mem_rd, 1'b0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_ddone", data_done, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        data_req = 1'b0;
        tick();
        chk("mid_rst_no_done", data_done, 1'b0);
        rst_n = 1'b1;

        // Both requesters held high with zero-wait memory.
        fetch_req  = 1'b1;
        fetch_addr = 32'h100;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h200;
        data_wdata = 32'hAB;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h33;
        overlap    = 0;
        bad_addr   = 0;
        n_done     = 0;
        for (int c = 0; c < 30 && n_done < 4; c++) begin
            tick();
            if (mem_rd && mem_wr) overlap++;
            if (fetch_done && data_done) overlap++;
            if (mem_rd && mem_addr != 32'h100) bad_addr++;
            if (mem_wr && mem_addr != 32'h200) bad_addr++;
            if (fetch_done) begin
                order[n_done] = 32'd0;
                n_done++;
            end else if (data_done) begin
                order[n_done] = 32'd1;
                n_done++;
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        mem_ack   = 1'b0;
        chk("rr_count", n_done, 4);
        if (n_done == 4) begin
            chk("rr_order0_fetch", order[0], 32'd0);
            chk("rr_order1_data", order[1], 32'd1);
            chk("rr_order2_fetch", order[2], 32'd0);
            chk("rr_order3_data", order[3], 32'd1);
        end
        chk("rr_overlap", overlap, 0);
        chk("rr_addr", bad_addr, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
